// File: rtl/nor_gate.sv
// Registered 16-bit two-operand NOR unit with popcount and all-clear flag.
// Define NOR_GATE_STATS_EN to build the saturating all-clear hit counter.
module nor_gate (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        gate_output,
    output logic [15:0] nor_vec,
    output logic [4:0]  ones_count,
    output logic        out_valid,
    output logic [15:0] hit_count
);

    logic [15:0] nor_d, nor_q;
    logic [4:0]  ones_d, ones_q;
    logic        gate_d, gate_q;
    logic        valid_q;

    always_comb begin
        nor_d  = ~(a | b);
        ones_d = 5'd0;
        for (int i = 0; i < 16; i++) begin
            ones_d = ones_d + 5'(nor_d[i]);
        end
        // Derived from nor_d so flag, vector and count can never disagree.
        gate_d = &nor_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nor_q   <= 16'h0000;
            ones_q  <= 5'd0;
            gate_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (in_valid) begin
            nor_q   <= nor_d;
            ones_q  <= ones_d;
            gate_q  <= gate_d;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign nor_vec     = nor_q;
    assign ones_count  = ones_q;
    assign gate_output = gate_q;
    assign out_valid   = valid_q;

`ifdef NOR_GATE_STATS_EN
    logic [15:0] hit_d, hit_q;

    always_comb begin
        hit_d = hit_q;
        if (in_valid && gate_d && (hit_q != 16'hFFFF)) begin
            hit_d = hit_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= 16'h0000;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_count = hit_q;
`else
    assign hit_count = 16'h0000;
`endif

endmodule

// File: tb/tb_nor_gate.sv
// Self-checking bench for nor_gate: directed vector table plus reset, idle,
// saturation and mid-stream reset sequences.
module tb_nor_gate;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        gate_output;
    logic [15:0] nor_vec;
    logic [4:0]  ones_count;
    logic        out_valid;
    logic [15:0] hit_count;

    int unsigned total;
    int unsigned bad;

`ifdef NOR_GATE_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    nor_gate u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .gate_output(gate_output),
        .nor_vec    (nor_vec),
        .ones_count (ones_count),
        .out_valid  (out_valid),
        .hit_count  (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] nv;
        logic        g;
        logic [4:0]  ones;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] nv, input logic g,
                             input logic [4:0] ones, input logic v, input logic [15:0] hit);
        check({tag, ".nor_vec"}, 32'(nor_vec), 32'(nv));
        check({tag, ".gate_output"}, 32'(gate_output), 32'(g));
        check({tag, ".ones_count"}, 32'(ones_count), 32'(ones));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".hit_count"}, 32'(hit_count), 32'(hit));
    endtask

    logic [15:0] exp_hit;

    initial begin
        total    = 0;
        bad      = 0;
        exp_hit  = 16'h0000;

        vecs[0] = '{16'h1082, 16'h1082, 16'hEF7D, 1'b0, 5'd13};
        vecs[1] = '{16'h4648, 16'h1082, 16'hA935, 1'b0, 5'd8};
        vecs[2] = '{16'h0011, 16'h1082, 16'hEF6C, 1'b0, 5'd11};
        vecs[3] = '{16'h0000, 16'h0000, 16'hFFFF, 1'b1, 5'd16};
        vecs[4] = '{16'hFFFF, 16'h0000, 16'h0000, 1'b0, 5'd0};
        vecs[5] = '{16'h8000, 16'h0001, 16'h7FFE, 1'b0, 5'd14};
        vecs[6] = '{16'h0000, 16'h0000, 16'hFFFF, 1'b1, 5'd16};

        // Reset with a live sample presented: it must be discarded.
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        step();
        step();
        check_all("reset", 16'h0000, 1'b0, 5'd0, 1'b0, 16'h0000);

        // Back-to-back table vectors, each checked one cycle after acceptance.
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            a        = vecs[i].a;
            b        = vecs[i].b;
            in_valid = 1'b1;
            step();
            if (StatsEn && vecs[i].g) exp_hit = exp_hit + 16'd1;
            check_all($sformatf("vec%0d", i), vecs[i].nv, vecs[i].g, vecs[i].ones, 1'b1, exp_hit);
        end

        // Idle: outputs hold the last result, out_valid drops.
        in_valid = 1'b0;
        a        = 16'h1234;
        b        = 16'h0000;
        step();
        check_all("idle1", 16'hFFFF, 1'b1, 5'd16, 1'b0, exp_hit);
        step();
        check_all("idle2", 16'hFFFF, 1'b1, 5'd16, 1'b0, exp_hit);

        // Saturation: 65537 accepted zero samples after reset.
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'h0000;
        b        = 16'h0000;
        step();
        check("sat.reset_hit", 32'(hit_count), 32'h0);
        rst = 1'b0;
        for (int n = 1; n <= 65537; n++) begin
            step();
            if (n == 65534) check("sat.hit_65534", 32'(hit_count), StatsEn ? 32'hFFFE : 32'h0);
            if (n == 65535) check("sat.hit_65535", 32'(hit_count), StatsEn ? 32'hFFFF : 32'h0);
        end
        check_all("sat.end", 16'hFFFF, 1'b1, 5'd16, 1'b1, StatsEn ? 16'hFFFF : 16'h0000);

        // Mid-stream reset during continuous zero samples.
        rst = 1'b1;
        step();
        check_all("midrst", 16'h0000, 1'b0, 5'd0, 1'b0, 16'h0000);
        rst = 1'b0;
        step();
        check_all("resume1", 16'hFFFF, 1'b1, 5'd16, 1'b1, StatsEn ? 16'h0001 : 16'h0000);
        a = 16'h1082;
        b = 16'h1082;
        step();
        check_all("resume2", 16'hEF7D, 1'b0, 5'd13, 1'b1, StatsEn ? 16'h0001 : 16'h0000);
        in_valid = 1'b0;
        step();
        check_all("resume_idle", 16'hEF7D, 1'b0, 5'd13, 1'b0, StatsEn ? 16'h0001 : 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
